// File: rtl/pulse_period_checker.sv
// pulse_period_checker: locks onto a pulse stream of period N and flags
// missing or early pulses once locked.
//   clk, rst (sync, active-high), pulse_in
//   locked, err_pulse, period_out[CNT_W], err_count[ERR_W]
// PULSE_CHECK_TOL_EN: accept periods N-1..N+1 (lower bound >= 1).
module pulse_period_checker #(
  parameter int unsigned N          = 3,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] period_out,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW:0] LOCK_V = (GW+1)'(LOCK_COUNT);

`ifdef PULSE_CHECK_TOL_EN
  localparam logic [CNT_W-1:0] LO_V   = CNT_W'((N > 1) ? N - 1 : 1);
  localparam logic [CNT_W-1:0] HI_V   = CNT_W'(N + 1);
  localparam logic [CNT_W-1:0] MISS_V = CNT_W'(N + 1);
`else
  localparam logic [CNT_W-1:0] LO_V   = CNT_W'(N);
  localparam logic [CNT_W-1:0] HI_V   = CNT_W'(N);
  localparam logic [CNT_W-1:0] MISS_V = CNT_W'(N);
`endif

  typedef enum logic [1:0] {SEARCH, TRACK, LOCK} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] gap, gap_n, gap_inc, period_n;
  logic [GW-1:0]    good, good_n;
  logic [GW:0]      good_inc;
  logic             err_n;
  logic [ERR_W-1:0] err_count_n;
  logic             p_good;

  assign gap_inc  = (gap == '1) ? gap : gap + CNT_W'(1);
  assign good_inc = {1'b0, good} + (GW+1)'(1);
  // On a pulse cycle the measured period is the current gap value.
  assign p_good   = (gap >= LO_V) && (gap <= HI_V);
  assign locked   = (state == LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      gap        <= '0;
      good       <= '0;
      err_pulse  <= 1'b0;
      period_out <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      gap        <= gap_n;
      good       <= good_n;
      err_pulse  <= err_n;
      period_out <= period_n;
      err_count  <= err_count_n;
    end
  end

  always_comb begin
    state_n  = state;
    gap_n    = gap_inc;
    good_n   = good;
    period_n = period_out;
    err_n    = 1'b0;
    unique case (state)
      SEARCH: begin
        if (pulse_in) begin
          state_n = TRACK;
          good_n  = '0;
          gap_n   = CNT_W'(1);
        end
      end
      TRACK: begin
        if (pulse_in) begin
          gap_n    = CNT_W'(1);
          period_n = gap;
          if (p_good) begin
            if (good_inc == LOCK_V) begin
              state_n = LOCK;
              good_n  = '0;
            end else begin
              good_n = good_inc[GW-1:0];
            end
          end else begin
            good_n = '0;
          end
        end else if (gap >= MISS_V) begin
          // Pulse is already late: the current run cannot be good.
          good_n = '0;
        end
      end
      LOCK: begin
        if (pulse_in) begin
          gap_n    = CNT_W'(1);
          period_n = gap;
          if (!p_good) begin
            err_n   = 1'b1;
            state_n = TRACK;
            good_n  = '0;
          end
        end else if (gap == MISS_V) begin
          // Missing pulse: gap keeps counting so the next period is long.
          err_n   = 1'b1;
          state_n = TRACK;
          good_n  = '0;
        end
      end
      default: state_n = SEARCH;
    endcase
    err_count_n = (err_n && (err_count != '1)) ? err_count + ERR_W'(1) : err_count;
  end

endmodule

// File: tb/tb_pulse_period_checker.sv
module tb_pulse_period_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse_in = 1'b0;

  logic       lk_a, ep_a, lk_b, ep_b, lk_c, ep_c;
  logic [7:0] per_a, ec_a, per_b, ec_b, ec_c;
  logic [3:0] per_c;

  always #5 clk = ~clk;

  pulse_period_checker #(.N(3), .CNT_W(8), .LOCK_COUNT(4), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .locked(lk_a), .err_pulse(ep_a),
    .period_out(per_a), .err_count(ec_a));
  pulse_period_checker #(.N(1), .CNT_W(8), .LOCK_COUNT(4), .ERR_W(8)) dut_b (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .locked(lk_b), .err_pulse(ep_b),
    .period_out(per_b), .err_count(ec_b));
  pulse_period_checker #(.N(3), .CNT_W(4), .LOCK_COUNT(4), .ERR_W(8)) dut_c (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .locked(lk_c), .err_pulse(ep_c),
    .period_out(per_c), .err_count(ec_c));

  wire [17:0] act_a = {lk_a, ep_a, per_a, ec_a};
  wire [17:0] act_b = {lk_b, ep_b, per_b, ec_b};
  wire [13:0] act_c = {lk_c, ep_c, per_c, ec_c};

  // Reference model: time-stamp based. Period = cycles since last pulse time.
  typedef struct {
    bit seen; int last; int run; bit lock; bit err; int period; int errs;
  } mdl_t;

  mdl_t ma, mb, mc;
  int   now = 0;
  int   tests = 0;
  int   fails = 0;

  function automatic mdl_t step(mdl_t m, bit r, bit p, int t, int n, int cw);
    int maxv, d, lo, hi, miss;
    bit ok;
    maxv = (1 << cw) - 1;
`ifdef PULSE_CHECK_TOL_EN
    lo = (n > 1) ? n - 1 : 1; hi = n + 1; miss = n + 1;
`else
    lo = n; hi = n; miss = n;
`endif
    if (r) begin
      m = '{default: 0};
      return m;
    end
    m.err = 0;
    if (!m.seen) begin
      if (p) begin m.seen = 1; m.last = t; m.run = 0; end
      return m;
    end
    d = t - m.last;
    if (d > maxv) d = maxv;
    ok = (d >= lo) && (d <= hi);
    if (p) begin
      m.period = d;
      m.last = t;
      if (m.lock) begin
        if (!ok) begin m.err = 1; m.lock = 0; m.run = 0; end
      end else if (ok) begin
        m.run++;
        if (m.run == 4) begin m.lock = 1; m.run = 0; end
      end else m.run = 0;
    end else if (m.lock) begin
      if (d == miss) begin m.err = 1; m.lock = 0; m.run = 0; end
    end else if (d >= miss) m.run = 0;
    if (m.err && m.errs < 255) m.errs++;
    return m;
  endfunction

  function automatic logic [17:0] pk8(mdl_t m);
    return {m.lock, m.err, 8'(m.period), 8'(m.errs)};
  endfunction
  function automatic logic [13:0] pk4(mdl_t m);
    return {m.lock, m.err, 4'(m.period), 8'(m.errs)};
  endfunction

  task automatic tick(input bit r, input bit p);
    rst = r;
    pulse_in = p;
    @(posedge clk);
    ma = step(ma, r, p, now, 3, 8);
    mb = step(mb, r, p, now, 1, 8);
    mc = step(mc, r, p, now, 3, 4);
    now++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1, 0);
    tick(1, 1);
    tests++; if (act_a !== 18'd0) begin fails++; $display("FAIL reset_a act=%h exp=0", act_a); end
    tests++; if (act_b !== 18'd0) begin fails++; $display("FAIL reset_b act=%h exp=0", act_b); end
    tests++; if (act_c !== 14'd0) begin fails++; $display("FAIL reset_c act=%h exp=0", act_c); end
  endtask

  task automatic test_lock_sequence();
    for (int i = 0; i < 18; i++) begin
      tick(0, (i % 3) == 0);
      tests++; if (act_a !== pk8(ma)) begin fails++; $display("FAIL lock_seq_a i=%0d act=%h exp=%h", i, act_a, pk8(ma)); end
      tests++; if (act_c !== pk4(mc)) begin fails++; $display("FAIL lock_seq_c i=%0d act=%h exp=%h", i, act_c, pk4(mc)); end
      tests++; if (ep_a !== 1'b0) begin fails++; $display("FAIL lock_seq_noerr i=%0d act=%b exp=0", i, ep_a); end
      if (i == 3) begin tests++; if (per_a !== 8'd3) begin fails++; $display("FAIL lock_seq_period act=%0d exp=3", per_a); end end
      if (i == 11) begin tests++; if (lk_a !== 1'b0) begin fails++; $display("FAIL lock_seq_early act=%b exp=0", lk_a); end end
      if (i == 12) begin tests++; if (lk_a !== 1'b1) begin fails++; $display("FAIL lock_seq_lock act=%b exp=1", lk_a); end end
    end
  endtask

  task automatic test_missing_pulse();
    for (int i = 18; i < 40; i++) begin
      tick(0, ((i % 3) == 0) && (i != 21));
      tests++; if (act_a !== pk8(ma)) begin fails++; $display("FAIL missing_a i=%0d act=%h exp=%h", i, act_a, pk8(ma)); end
      tests++; if (act_b !== pk8(mb)) begin fails++; $display("FAIL missing_b i=%0d act=%h exp=%h", i, act_b, pk8(mb)); end
      if (i == 21) begin
        tests++; if ({lk_a, ep_a, ec_a} !== {1'b0, 1'b1, 8'd1}) begin fails++; $display("FAIL missing_err act=%b%b/%0d exp=01/1", lk_a, ep_a, ec_a); end
      end
      if (i == 22) begin tests++; if (ep_a !== 1'b0) begin fails++; $display("FAIL missing_strobe act=%b exp=0", ep_a); end end
      if (i == 35) begin tests++; if (lk_a !== 1'b0) begin fails++; $display("FAIL missing_relock_early act=%b exp=0", lk_a); end end
      if (i == 36) begin tests++; if (lk_a !== 1'b1) begin fails++; $display("FAIL missing_relock act=%b exp=1", lk_a); end end
    end
  endtask

  task automatic test_extra_pulse();
    tick(1, 0);
    for (int i = 0; i < 25; i++) begin
      tick(0, ((i % 3) == 0) || (i == 16));
      tests++; if (act_a !== pk8(ma)) begin fails++; $display("FAIL extra_a i=%0d act=%h exp=%h", i, act_a, pk8(ma)); end
      if (i == 16) begin
        tests++; if ({lk_a, ep_a, per_a, ec_a} !== {1'b0, 1'b1, 8'd1, 8'd1}) begin
          fails++; $display("FAIL extra_err act=%b%b/%0d/%0d exp=01/1/1", lk_a, ep_a, per_a, ec_a); end
      end
    end
  endtask

  task automatic test_continuous_high();
    tick(1, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 1);
      tests++; if (act_a !== pk8(ma)) begin fails++; $display("FAIL high_a i=%0d act=%h exp=%h", i, act_a, pk8(ma)); end
      tests++; if (act_b !== pk8(mb)) begin fails++; $display("FAIL high_b i=%0d act=%h exp=%h", i, act_b, pk8(mb)); end
      tests++; if ({lk_a, ec_a} !== 9'd0) begin fails++; $display("FAIL high_nolock act=%b/%0d exp=0/0", lk_a, ec_a); end
      if (i >= 1) begin tests++; if (per_a !== 8'd1) begin fails++; $display("FAIL high_period i=%0d act=%0d exp=1", i, per_a); end end
      if (i == 3) begin tests++; if (lk_b !== 1'b0) begin fails++; $display("FAIL high_n1_early act=%b exp=0", lk_b); end end
      if (i == 4) begin tests++; if (lk_b !== 1'b1) begin fails++; $display("FAIL high_n1_lock act=%b exp=1", lk_b); end end
    end
  endtask

  task automatic test_saturation();
    tick(1, 0);
    tick(0, 1);
    for (int i = 0; i < 30; i++) tick(0, 0);
    tick(0, 1);
    tests++; if (per_c !== 4'd15) begin fails++; $display("FAIL sat_c act=%0d exp=15", per_c); end
    tests++; if (per_a !== 8'd31) begin fails++; $display("FAIL sat_a act=%0d exp=31", per_a); end
    tests++; if (lk_c !== 1'b0) begin fails++; $display("FAIL sat_nolock act=%b exp=0", lk_c); end
    tests++; if (act_c !== pk4(mc)) begin fails++; $display("FAIL sat_model act=%h exp=%h", act_c, pk4(mc)); end
  endtask

  task automatic test_reset_while_locked();
    tick(1, 0);
    for (int i = 0; i < 51; i++) begin
      tick(0, ((i % 3) == 0) || (i == 16) || (i == 34));
      tests++; if (act_a !== pk8(ma)) begin fails++; $display("FAIL rst_lock_a i=%0d act=%h exp=%h", i, act_a, pk8(ma)); end
    end
    tests++; if ({lk_a, ec_a} !== {1'b1, 8'd2}) begin fails++; $display("FAIL rst_lock_pre act=%b/%0d exp=1/2", lk_a, ec_a); end
    tick(1, 1);
    tests++; if (act_a !== 18'd0) begin fails++; $display("FAIL rst_lock_post act=%h exp=0", act_a); end
    tick(0, 0);
    tests++; if (act_a !== 18'd0) begin fails++; $display("FAIL rst_lock_idle act=%h exp=0", act_a); end
  endtask

  task automatic test_random();
    int ph;
    int mode;
    bit p;
    tick(1, 0);
    ph = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 250) == 0) mode = $urandom_range(0, 2);
      case (mode)
        0: begin p = (ph == 0); ph = (ph + 1) % 3; if ($urandom_range(0, 29) == 0) p = ~p; end
        1: p = ($urandom_range(0, 1) == 1);
        default: p = ($urandom_range(0, 19) != 0);
      endcase
      tick($urandom_range(0, 599) == 0, p);
      tests++; if (act_a !== pk8(ma)) begin fails++; $display("FAIL rand_a i=%0d act=%h exp=%h", i, act_a, pk8(ma)); end
      tests++; if (act_b !== pk8(mb)) begin fails++; $display("FAIL rand_b i=%0d act=%h exp=%h", i, act_b, pk8(mb)); end
      tests++; if (act_c !== pk4(mc)) begin fails++; $display("FAIL rand_c i=%0d act=%h exp=%h", i, act_c, pk4(mc)); end
    end
  endtask

`ifdef PULSE_CHECK_TOL_EN
  task automatic test_tolerance();
    int nxt;
    tick(1, 0);
    nxt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, i == nxt);
      if (i == nxt) nxt = nxt + (((nxt / 7) * 7 == nxt) ? 3 : 4);
      tests++; if (act_a !== pk8(ma)) begin fails++; $display("FAIL tol_a i=%0d act=%h exp=%h", i, act_a, pk8(ma)); end
      tests++; if (ep_a !== 1'b0) begin fails++; $display("FAIL tol_noerr i=%0d act=%b exp=0", i, ep_a); end
    end
    tests++; if (lk_a !== 1'b1) begin fails++; $display("FAIL tol_lock act=%b exp=1", lk_a); end
  endtask
`endif

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    mc = '{default: 0};
    test_reset();
    test_lock_sequence();
    test_missing_pulse();
    test_extra_pulse();
    test_continuous_high();
    test_saturation();
    test_reset_while_locked();
`ifdef PULSE_CHECK_TOL_EN
    test_tolerance();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
